// File: rtl/bist_sequencer_if.sv
// bist_sequencer_if: harness, TPG, ORA and fault-injector signals.
// master = sequencer side, slave = environment side.
interface bist_sequencer_if #(
    parameter int FW = 8
);
    logic          START;
    logic          TPG_END;
    logic          ORA_RES;
    logic          TPG_RESET;
    logic          ORA_RESET;
    logic          TPG_EN;
    logic          INC;
    logic [FW-1:0] FAULT_SEL;
    logic [FW-1:0] DETECTED;
    logic          BUSY;
    logic          DONE;
    logic          GOLDEN_FAIL;
    logic          TIMEOUT_ERR;

    modport master (
        input  START, TPG_END, ORA_RES,
        output TPG_RESET, ORA_RESET, TPG_EN, INC,
        output FAULT_SEL, DETECTED,
        output BUSY, DONE, GOLDEN_FAIL, TIMEOUT_ERR
    );

    modport slave (
        output START, TPG_END, ORA_RES,
        input  TPG_RESET, ORA_RESET, TPG_EN, INC,
        input  FAULT_SEL, DETECTED,
        input  BUSY, DONE, GOLDEN_FAIL, TIMEOUT_ERR
    );
endinterface

// File: rtl/bist_sequencer.sv
// bist_sequencer: golden run plus NUM_FAULTS fault runs of the BIST loop.
// All outputs are registered; control lines are decoded from next state.
module bist_sequencer #(
    parameter int SETUP_CYCLES = 10,
    parameter int NUM_FAULTS   = 16,
    parameter int FW           = 8,
    parameter int MAX_RUN      = 1024
) (
    input logic              clk,
    input logic              RESET,
    bist_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, SETUP, RUN, CHECK, NEXT, FIN
    } state_t;

    localparam int SW = $clog2(SETUP_CYCLES + 1);

    state_t        state, state_d;
    logic [SW-1:0] setup_cnt, setup_cnt_d;
    logic [15:0]   wdog, wdog_d;
    logic [FW-1:0] fault_sel, fault_sel_d;
    logic [FW-1:0] detected, detected_d;
    logic          golden_fail, golden_fail_d;
    logic          timeout_err, timeout_err_d;
    logic          tpg_reset_d, tpg_en_d, inc_d;
    logic          busy_d, done_d;

    always_comb begin
        state_d       = state;
        setup_cnt_d   = setup_cnt;
        wdog_d        = wdog;
        fault_sel_d   = fault_sel;
        detected_d    = detected;
        golden_fail_d = golden_fail;
        timeout_err_d = timeout_err;
        unique case (state)
            IDLE, FIN: begin
                if (bus.START) begin
                    state_d       = SETUP;
                    setup_cnt_d   = '0;
                    fault_sel_d   = '0;
                    detected_d    = '0;
                    golden_fail_d = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            SETUP: begin
                if (setup_cnt == SW'(SETUP_CYCLES - 1)) begin
                    state_d = RUN;
                    wdog_d  = '0;
                end else begin
                    setup_cnt_d = setup_cnt + SW'(1);
                end
            end
            RUN: begin
                wdog_d = wdog + 16'd1;
                // End of patterns wins over a coincident watchdog expiry.
                if (bus.TPG_END) begin
                    state_d = CHECK;
                end else if (wdog == 16'(MAX_RUN - 1)) begin
                    state_d       = FIN;
                    timeout_err_d = 1'b1;
                end
            end
            CHECK: begin
                if (fault_sel == '0 && bus.ORA_RES) begin
                    golden_fail_d = 1'b1;
                    state_d       = FIN;
                end else begin
                    if (bus.ORA_RES) begin
                        detected_d = detected + FW'(1);
                    end
                    if (fault_sel == FW'(NUM_FAULTS)) begin
                        state_d = FIN;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                fault_sel_d = fault_sel + FW'(1);
                setup_cnt_d = '0;
                state_d     = SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tpg_reset_d = (state_d == IDLE) || (state_d == SETUP) ||
                      (state_d == FIN);
        tpg_en_d    = (state_d == RUN);
        inc_d       = (state_d == NEXT);
        busy_d      = (state_d == SETUP) || (state_d == RUN) ||
                      (state_d == CHECK) || (state_d == NEXT);
        done_d      = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state         <= IDLE;
            setup_cnt     <= '0;
            wdog          <= '0;
            fault_sel     <= '0;
            detected      <= '0;
            golden_fail   <= 1'b0;
            timeout_err   <= 1'b0;
            bus.TPG_RESET <= 1'b1;
            bus.ORA_RESET <= 1'b1;
            bus.TPG_EN    <= 1'b0;
            bus.INC       <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b0;
        end else begin
            state         <= state_d;
            setup_cnt     <= setup_cnt_d;
            wdog          <= wdog_d;
            fault_sel     <= fault_sel_d;
            detected      <= detected_d;
            golden_fail   <= golden_fail_d;
            timeout_err   <= timeout_err_d;
            bus.TPG_RESET <= tpg_reset_d;
            bus.ORA_RESET <= tpg_reset_d;
            bus.TPG_EN    <= tpg_en_d;
            bus.INC       <= inc_d;
            bus.BUSY      <= busy_d;
            bus.DONE      <= done_d;
        end
    end

    assign bus.FAULT_SEL   = fault_sel;
    assign bus.DETECTED    = detected;
    assign bus.GOLDEN_FAIL = golden_fail;
    assign bus.TIMEOUT_ERR = timeout_err;
endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: cycle timeline model of whole BIST sessions,
// built from per-run pattern lengths and verdicts, compared each cycle.
module tb_bist_sequencer;
    localparam int SC = 3;
    localparam int NF = 4;
    localparam int MR = 24;

    localparam int P_IDLE  = 0;
    localparam int P_SETUP = 1;
    localparam int P_RUN   = 2;
    localparam int P_CHECK = 3;
    localparam int P_NEXT  = 4;
    localparam int P_FIN   = 5;

    typedef int len_t[NF+1];
    typedef bit ora_t[NF+1];

    typedef struct packed {
        logic        start;
        logic        tpg_end;
        logic        ora;
        logic [23:0] obs;
    } ent_t;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    bist_sequencer_if #(.FW(8)) bus ();

    bist_sequencer #(
        .SETUP_CYCLES(SC),
        .NUM_FAULTS  (NF),
        .FW          (8),
        .MAX_RUN     (MR)
    ) dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus)
    );

    ent_t        q[$];
    logic [23:0] got[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  m_fsel, m_det;
    logic        m_gf, m_te;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // obs: {tpg_rst, ora_rst, en, inc, busy, done, gfail, tout, fsel, det}
    function automatic logic [23:0] ob(int ph);
        logic rst, en, inc, busy, done;
        rst  = (ph == P_IDLE) || (ph == P_SETUP) || (ph == P_FIN);
        en   = (ph == P_RUN);
        inc  = (ph == P_NEXT);
        busy = (ph >= P_SETUP) && (ph <= P_NEXT);
        done = (ph == P_FIN);
        return {rst, rst, en, inc, busy, done, m_gf, m_te, m_fsel, m_det};
    endfunction

    function automatic logic [23:0] sample();
        return {bus.TPG_RESET, bus.ORA_RESET, bus.TPG_EN, bus.INC,
                bus.BUSY, bus.DONE, bus.GOLDEN_FAIL, bus.TIMEOUT_ERR,
                bus.FAULT_SEL, bus.DETECTED};
    endfunction

    task automatic push(int ph, logic s, logic e, logic o);
        q.push_back('{start: s, tpg_end: e, ora: o, obs: ob(ph)});
    endtask

    // len[r]=0 means TPG_END never comes; else TPG_END on RUN cycle len[r].
    task automatic build_session(input len_t len, input ora_t orr,
                                 input int first_ph);
        push(first_ph, 1'b1, rb(), rb());
        m_fsel = '0;
        m_det  = '0;
        m_gf   = 1'b0;
        m_te   = 1'b0;
        for (int r = 0; r <= NF; r++) begin
            for (int c = 0; c < SC; c++) push(P_SETUP, rb(), rb(), rb());
            if (len[r] == 0) begin
                for (int j = 0; j < MR; j++) push(P_RUN, rb(), 1'b0, rb());
                m_te = 1'b1;
                break;
            end
            for (int j = 1; j <= len[r]; j++)
                push(P_RUN, rb(), 1'(j == len[r]), rb());
            push(P_CHECK, rb(), rb(), orr[r]);
            if (r == 0 && orr[r]) begin
                m_gf = 1'b1;
                break;
            end
            if (orr[r]) m_det = m_det + 8'd1;
            if (r == NF) break;
            push(P_NEXT, rb(), rb(), rb());
            m_fsel = m_fsel + 8'd1;
        end
        push(P_FIN, 1'b0, rb(), rb());
    endtask

    task automatic play(input int n);
        got.delete();
        for (int i = 0; i < n; i++) begin
            got.push_back(sample());
            bus.START   = q[i].start;
            bus.TPG_END = q[i].tpg_end;
            bus.ORA_RES = q[i].ora;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_session(output len_t len, output ora_t orr);
        for (int r = 0; r <= NF; r++) begin
            len[r] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MR);
            orr[r] = bit'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        m_fsel = '0; m_det = '0; m_gf = 1'b0; m_te = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.START = rb(); bus.TPG_END = rb(); bus.ORA_RES = rb();
            @(posedge clk);
            #1;
            vectors++;
            if (sample() !== ob(P_IDLE)) begin
                errors++;
                $display("FAIL reset cyc %0d got %h want %h",
                         i, sample(), ob(P_IDLE));
            end
        end
        RESET = 1'b0;
        bus.START = 1'b0; bus.TPG_END = rb(); bus.ORA_RES = rb();
        @(posedge clk);
        #1;
        vectors++;
        if (sample() !== ob(P_IDLE)) begin
            errors++;
            $display("FAIL idle_hold got %h want %h", sample(), ob(P_IDLE));
        end
    endtask

    task automatic test_nominal();
        len_t len;
        ora_t orr;
        int   incs = 0;
        for (int r = 0; r <= NF; r++) begin
            len[r] = 20;
            orr[r] = (r == 1 || r == 3);
        end
        q.delete();
        build_session(len, orr, P_IDLE);
        play(q.size());
        foreach (got[i]) begin
            vectors++;
            if (got[i] !== q[i].obs) begin
                errors++;
                $display("FAIL nominal cyc %0d got %h want %h",
                         i, got[i], q[i].obs);
            end
            if (got[i][20]) incs++;
        end
        vectors++;
        if (incs != NF || bus.DETECTED !== 8'd2 || bus.FAULT_SEL !== 8'd4 ||
            bus.DONE !== 1'b1 || bus.GOLDEN_FAIL !== 1'b0) begin
            errors++;
            $display("FAIL nominal_result inc %0d det %0d fsel %0d want 4 2 4",
                     incs, bus.DETECTED, bus.FAULT_SEL);
        end
    endtask

    task automatic test_golden_fail();
        len_t len;
        ora_t orr;
        int   incs = 0;
        rand_session(len, orr);
        len[0] = $urandom_range(1, MR);
        orr[0] = 1'b1;
        q.delete();
        build_session(len, orr, P_FIN);
        play(q.size());
        foreach (got[i]) begin
            vectors++;
            if (got[i] !== q[i].obs) begin
                errors++;
                $display("FAIL golden cyc %0d got %h want %h",
                         i, got[i], q[i].obs);
            end
            if (got[i][20]) incs++;
        end
        vectors++;
        if (incs != 0 || bus.GOLDEN_FAIL !== 1'b1 || bus.DETECTED !== 8'd0) begin
            errors++;
            $display("FAIL golden_result inc %0d gf %b det %0d want 0 1 0",
                     incs, bus.GOLDEN_FAIL, bus.DETECTED);
        end
    endtask

    task automatic test_watchdog();
        len_t len;
        ora_t orr;
        int   runs = 0;
        rand_session(len, orr);
        len[0] = 0;
        q.delete();
        build_session(len, orr, P_FIN);
        play(q.size());
        foreach (got[i]) begin
            vectors++;
            if (got[i] !== q[i].obs) begin
                errors++;
                $display("FAIL wdog cyc %0d got %h want %h",
                         i, got[i], q[i].obs);
            end
            if (got[i][21]) runs++;
        end
        vectors++;
        if (runs != MR || bus.TIMEOUT_ERR !== 1'b1 || bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL wdog_result runs %0d tout %b want %0d 1",
                     runs, bus.TIMEOUT_ERR, MR);
        end
        for (int r = 0; r <= NF; r++) begin
            len[r] = MR;
            orr[r] = (r != 0) && bit'($urandom_range(0, 1));
        end
        q.delete();
        build_session(len, orr, P_FIN);
        play(q.size());
        foreach (got[i]) begin
            vectors++;
            if (got[i] !== q[i].obs) begin
                errors++;
                $display("FAIL wdog_edge cyc %0d got %h want %h",
                         i, got[i], q[i].obs);
            end
        end
        vectors++;
        if (bus.TIMEOUT_ERR !== 1'b0 || bus.FAULT_SEL !== 8'(NF)) begin
            errors++;
            $display("FAIL wdog_edge_result tout %b fsel %0d want 0 %0d",
                     bus.TIMEOUT_ERR, bus.FAULT_SEL, NF);
        end
    endtask

    task automatic test_reset_midrun();
        len_t len;
        ora_t orr;
        int   idx = -1;
        for (int r = 0; r <= NF; r++) begin
            len[r] = 5;
            orr[r] = (r != 0);
        end
        q.delete();
        build_session(len, orr, P_FIN);
        foreach (q[i])
            if (idx < 0 && q[i].obs[21] && q[i].obs[15:8] == 8'd2) idx = i;
        play(idx + 3);
        foreach (got[i]) begin
            vectors++;
            if (got[i] !== q[i].obs) begin
                errors++;
                $display("FAIL midrun cyc %0d got %h want %h",
                         i, got[i], q[i].obs);
            end
        end
        RESET = 1'b1;
        bus.START = 1'b1; bus.TPG_END = rb(); bus.ORA_RES = rb();
        @(posedge clk);
        #1;
        RESET = 1'b0;
        m_fsel = '0; m_det = '0; m_gf = 1'b0; m_te = 1'b0;
        vectors++;
        if (sample() !== ob(P_IDLE)) begin
            errors++;
            $display("FAIL midrun_reset got %h want %h", sample(), ob(P_IDLE));
        end
        rand_session(len, orr);
        q.delete();
        build_session(len, orr, P_IDLE);
        play(q.size());
        foreach (got[i]) begin
            vectors++;
            if (got[i] !== q[i].obs) begin
                errors++;
                $display("FAIL after_reset cyc %0d got %h want %h",
                         i, got[i], q[i].obs);
            end
        end
    endtask

    task automatic test_back_to_back();
        len_t len;
        ora_t orr;
        q.delete();
        for (int s = 0; s < 6; s++) begin
            rand_session(len, orr);
            build_session(len, orr, P_FIN);
        end
        play(q.size());
        foreach (got[i]) begin
            vectors++;
            if (got[i] !== q[i].obs) begin
                errors++;
                $display("FAIL b2b cyc %0d got %h want %h",
                         i, got[i], q[i].obs);
            end
        end
    endtask

    initial begin
        bus.START   = 1'b0;
        bus.TPG_END = 1'b0;
        bus.ORA_RES = 1'b0;
        RESET       = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_nominal();
        test_golden_fail();
        test_watchdog();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
